core_ifetch_responder: RTL and testbench

- Responder side of the stage-1 instruction fetch interface. Stage 1 issues fetch requests; this block accepts them, reads the backing instruction memory, and returns in-order responses.
- Sits between core stage 1 and the instruction memory port.
- Absorbs stage-1 backpressure with a response FIFO and credit-limited acceptance.
- Supports a pipeline flush that discards all requests still in flight.

---
 rtl/core_ifetch_responder_if.sv | 31 +++
 rtl/core_ifetch_responder.sv | 108 ++++++++++
 tb/tb_core_ifetch_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/core_ifetch_responder_if.sv
// Fetch request/response and instruction-memory read port bundle.
// slave = responder view, master = stage-1 / memory side view.
interface core_ifetch_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_fault;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_rdata;
  logic                  mem_fault;

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    input  mem_rdata, mem_fault,
    output req_ready, rsp_valid, rsp_data,
    output rsp_fault, mem_rd_en, mem_addr
  );

  modport master (
    output req_valid, req_addr, rsp_ready,
    output mem_rdata, mem_fault,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_fault, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/core_ifetch_responder.sv
// Instruction fetch responder: one-cycle memory pipe stage feeding an
// in-order response FIFO, with credit-limited acceptance and flush.
module core_ifetch_responder #(
  parameter int RSP_DEPTH  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  core_ifetch_responder_if.slave bus
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]          dat_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] flt_q;

  logic          pipe_v_q, pipe_v_d;
  logic          pipe_mis_q, pipe_mis_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ready;
  logic          accept;
  logic          aligned;
  logic          push;
  logic          pop;
  logic [CW:0]   used;
  logic [31:0]   push_dat;
  logic          push_flt;
  logic          rsp_v;

  // Pipe stage holds a credit too, so in-flight reads never overrun the FIFO
  assign used    = {1'b0, cnt_q} + {{CW{1'b0}}, pipe_v_q};
  assign ready   = rst_n & ~flush & (used < (CW+1)'(RSP_DEPTH));
  assign aligned = (bus.req_addr[1:0] == 2'b00);
  assign accept  = bus.req_valid & ready;

  assign rsp_v   = (cnt_q != '0);
  assign push    = pipe_v_q & ~flush;
  assign pop     = rsp_v & bus.rsp_ready & ~flush;

  assign push_flt = pipe_mis_q | bus.mem_fault;
  assign push_dat = push_flt ? 32'h0 : bus.mem_rdata;

  assign bus.req_ready = ready;
  assign bus.mem_rd_en = accept & aligned;
  assign bus.mem_addr  = bus.req_addr;
  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_data  = rsp_v ? dat_q[rptr_q] : 32'h0;
  assign bus.rsp_fault = rsp_v & flt_q[rptr_q];

  always_comb begin
    pipe_v_d   = accept;
    pipe_mis_d = accept & ~aligned;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    if (flush) begin
      pipe_v_d   = 1'b0;
      pipe_mis_d = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case (1'b1)
        (push & ~pop): cnt_d = cnt_q + 1'b1;
        (pop & ~push): cnt_d = cnt_q - 1'b1;
        default:       cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q   <= 1'b0;
      pipe_mis_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      pipe_v_q   <= pipe_v_d;
      pipe_mis_q <= pipe_mis_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through cnt_q
  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wptr_q] <= push_dat;
      flt_q[wptr_q] <= push_flt;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    push |-> (cnt_q != CW'(RSP_DEPTH))
  );
`endif

endmodule

// File: tb/tb_core_ifetch_responder.sv
// Randomized bench for core_ifetch_responder against a
// queue-of-outstanding-fetches reference model.
module tb_core_ifetch_responder;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic flush;

  core_ifetch_responder_if #(.ADDR_WIDTH(32)) bus ();

  core_ifetch_responder #(
    .RSP_DEPTH (DEPTH),
    .ADDR_WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        f;
    int          vis;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_img [logic [31:0]];
  logic        flt_img [logic [31:0]];

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc_n  = 0;
  logic        pend_rd = 1'b0;
  logic [31:0] pend_a  = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc_n, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return hsh(a);
  endfunction

  function automatic logic flt(input logic [31:0] a);
    logic [31:0] h;
    if (flt_img.exists(a)) return flt_img[a];
    h = hsh(a);
    return (h[10:8] == 3'b000);
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance model
  task automatic cyc(input logic v, input logic [31:0] a,
                     input logic rr, input logic fl);
    logic exp_rdy, exp_v, exp_rd, acc;
    ent_t e;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = rr;
    flush         = fl;
    if (pend_rd) begin
      bus.mem_rdata = rd(pend_a);
      bus.mem_fault = flt(pend_a);
    end else begin
      bus.mem_rdata = $urandom;
      bus.mem_fault = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    exp_rdy = !fl && (q.size() < DEPTH);
    exp_v   = (q.size() > 0) && (q[0].vis <= cyc_n);
    acc     = v && exp_rdy;
    exp_rd  = acc && (a[1:0] == 2'b00);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(exp_rd));
    if (exp_rd) chk("mem_addr", bus.mem_addr, a);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
    chk("rsp_data", bus.rsp_data, exp_v ? q[0].d : 32'h0);
    chk("rsp_fault", 32'(bus.rsp_fault), exp_v ? 32'(q[0].f) : 32'h0);
    if (fl) begin
      q.delete();
    end else begin
      if (exp_v && rr) void'(q.pop_front());
      if (acc) begin
        e.vis = cyc_n + 2;
        if (a[1:0] != 2'b00) begin
          e.d = 32'h0;
          e.f = 1'b1;
        end else begin
          e.f = flt(a);
          e.d = e.f ? 32'h0 : rd(a);
        end
        q.push_back(e);
      end
    end
    pend_rd = exp_rd;
    pend_a  = a;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, request still driven
  task automatic mid_reset();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h50;
    bus.rsp_ready = 1'b0;
    flush         = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(bus.rsp_valid), 32'h0);
    rst_n = 1'b1;
    q.delete();
    pend_rd = 1'b0;
    cyc_n++;
  endtask

  initial begin
    logic [31:0] a;
    int          rr_pct;
    int          v_pct;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1000;
    bus.rsp_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    bus.mem_fault = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_req_ready", 32'(bus.req_ready), 32'h0);
    chk("init_mem_rd_en", 32'(bus.mem_rd_en), 32'h0);
    chk("init_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("init_rsp_data", bus.rsp_data, 32'h0);
    chk("init_rsp_fault", 32'(bus.rsp_fault), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    mem_img[32'h1000] = 32'h0000_0013;
    flt_img[32'h1000] = 1'b0;
    cyc(1'b1, 32'h1000, 1'b1, 1'b0);
    idle(3);

    cyc(1'b1, 32'h1002, 1'b1, 1'b0);
    idle(3);

    for (int i = 0; i < 6; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
    idle(8);

    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
    idle(3);

    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h20 + 32'(i * 4), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    mem_img[32'h200] = 32'h0000_0200;
    flt_img[32'h200] = 1'b0;
    cyc(1'b1, 32'h200, 1'b1, 1'b0);
    idle(3);

    mem_img[32'h300] = 32'hDEAD_BEEF;
    flt_img[32'h300] = 1'b1;
    cyc(1'b1, 32'h300, 1'b1, 1'b0);
    idle(3);
    cyc(1'b1, 32'h40, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    mid_reset();
    idle(3);

    rr_pct = 100;
    v_pct  = 80;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        rr_pct = $urandom_range(10, 100);
        v_pct  = $urandom_range(30, 100);
      end
      a = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 999) == 0) begin
        mid_reset();
      end else begin
        cyc(1'($urandom_range(0, 99) < v_pct), a,
            1'($urandom_range(0, 99) < rr_pct),
            1'($urandom_range(0, 39) == 0));
      end
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
